// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read port bundle for the multi-port register file
interface regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                      we;
    logic [WIDTH/8-1:0]        wstrb;
    logic [ADDR_W-1:0]         waddr;
    logic [WIDTH-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]  raddr;
    logic [NUM_RD*WIDTH-1:0]   rdata;

    modport master (output we, wstrb, waddr, wdata, raddr, input rdata);
    modport slave  (input we, wstrb, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - GPR file: NUM_RD async read ports, one byte-strobed sync write port
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_ok;
    logic [ADDR_W-1:0] ra   [NUM_RD];
    logic [WIDTH-1:0]  word [NUM_RD];

    // An address is live when it names real storage and is not the hardwired zero register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
        return in_range && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = bus.we && addr_live(bus.waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (bus.waddr == ADDR_W'(r)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bus.wstrb[b]) begin
                            mem[r][8*b +: 8] <= bus.wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Decoded read mux: out-of-range addresses match no entry and fall through to zero.
    always_comb begin
        bus.rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k]   = bus.raddr[k*ADDR_W +: ADDR_W];
            word[k] = '0;
            for (int r = 0; r < DEPTH; r++) begin
                if (ra[k] == ADDR_W'(r)) begin
                    word[k] = mem[r];
                end
            end
            if (!addr_live(ra[k])) begin
                word[k] = '0;
            end
            if ((BYPASS != 0) && rst_n && wr_ok && (ra[k] == bus.waddr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wstrb[b]) begin
                        word[k][8*b +: 8] = bus.wdata[8*b +: 8];
                    end
                end
            end
            bus.rdata[k*WIDTH +: WIDTH] = word[k];
        end
    end
endmodule
